ingress_serializer: RTL and testbench

INGRESS_SERIALIZER -- requirements
Module: ingress_serializer

---
 rtl/ingress_serializer.sv | 116 +++++++++++
 tb/tb_ingress_serializer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_serializer.sv
// Serializes a multi-slot commit bundle into one slot per cycle, lowest pending index first.
// Optional ingress stall counter output when INGRESS_STALL_CNT_EN is defined.
module ingress_serializer #(
   parameter  int NRET = 2,
   parameter  int DW   = 64,
   localparam int IW   = (NRET > 1) ? $clog2(NRET) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   input  logic [NRET-1:0]     in_slot_valid_i,
   input  logic [NRET*DW-1:0]  in_data_i,
   output logic                in_ready_o,
   output logic                out_valid_o,
   output logic [DW-1:0]       out_data_o,
   output logic [IW-1:0]       out_idx_o,
   output logic                out_last_o,
   input  logic                out_ready_i,
   input  logic                flush_i,
   output logic                busy_o
`ifdef INGRESS_STALL_CNT_EN
   ,output logic [15:0]        stall_cnt_o
`endif
);

   typedef enum logic {S_IDLE, S_DRAIN} state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [NRET-1:0]     r_pend;
   logic [NRET-1:0]     w_pend_nx;
   logic [NRET*DW-1:0]  r_data;
   logic [NRET-1:0]     w_lowbit;
   logic                w_drain;
   logic                w_out_vld;
   logic                w_last;
   logic [IW-1:0]       w_idx;
   logic [DW-1:0]       w_dat;
   logic                w_in_rdy;
   logic                w_acc;
   logic                w_hs;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_pend  <= w_pend_nx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data <= '0;
      end else if (w_acc) begin
         r_data <= in_data_i;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_pend_nx  = r_pend;
      w_idx      = '0;
      w_dat      = '0;
      // Isolates the lowest set bit of the pending mask (one-hot).
      w_lowbit   = r_pend & (~r_pend + NRET'(1));
      w_drain    = (r_state == S_DRAIN);
      w_out_vld  = w_drain && !flush_i;
      w_last     = w_out_vld && ((r_pend & ~w_lowbit) == '0);
      if (w_drain) begin
         for (int k = 0; k < NRET; k++) begin
            if (w_lowbit[k]) begin
               w_idx = IW'(k);
               w_dat = r_data[k*DW +: DW];
            end
         end
      end
      w_in_rdy = !flush_i && (!w_drain || (w_last && out_ready_i));
      w_acc    = in_valid_i && w_in_rdy;
      w_hs     = w_out_vld && out_ready_i;

      if (flush_i) begin
         w_pend_nx  = '0;
         w_state_nx = S_IDLE;
      end else if (w_acc) begin
         w_pend_nx  = in_slot_valid_i;
         w_state_nx = (in_slot_valid_i != '0) ? S_DRAIN : S_IDLE;
      end else if (w_hs) begin
         w_pend_nx  = r_pend & ~w_lowbit;
         w_state_nx = w_last ? S_IDLE : S_DRAIN;
      end
   end

   assign in_ready_o  = w_in_rdy;
   assign out_valid_o = w_out_vld;
   assign out_data_o  = w_dat;
   assign out_idx_o   = w_idx;
   assign out_last_o  = w_last;
   assign busy_o      = w_drain;

`ifdef INGRESS_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
      end else if (in_valid_i && !w_in_rdy && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ingress_serializer.sv
// Bench for ingress_serializer (NRET=2, DW=32): queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ingress_serializer;

   localparam int NRET = 2;
   localparam int DW   = 32;
   localparam int IW   = 1;

   logic            clk_i;
   logic            rst_ni;
   logic            in_valid_i;
   logic [NRET-1:0] in_slot_valid_i;
   logic [NRET*DW-1:0] in_data_i;
   logic            in_ready_o;
   logic            out_valid_o;
   logic [DW-1:0]   out_data_o;
   logic [IW-1:0]   out_idx_o;
   logic            out_last_o;
   logic            out_ready_i;
   logic            flush_i;
   logic            busy_o;
`ifdef INGRESS_STALL_CNT_EN
   logic [15:0]     stall_cnt_o;
`endif

   ingress_serializer #(.NRET(NRET), .DW(DW)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .in_valid_i      (in_valid_i),
      .in_slot_valid_i (in_slot_valid_i),
      .in_data_i       (in_data_i),
      .in_ready_o      (in_ready_o),
      .out_valid_o     (out_valid_o),
      .out_data_o      (out_data_o),
      .out_idx_o       (out_idx_o),
      .out_last_o      (out_last_o),
      .out_ready_i     (out_ready_i),
      .flush_i         (flush_i),
      .busy_o          (busy_o)
`ifdef INGRESS_STALL_CNT_EN
      ,.stall_cnt_o    (stall_cnt_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the slots still owed from the current bundle, in emission order.
   typedef struct {
      logic [DW-1:0] d;
      int            idx;
   } slot_t;

   slot_t q[$];
   int    mcnt;

   always @(posedge clk_i or negedge rst_ni) begin
      bit mrdy;
      bit hs;
      if (!rst_ni) begin
         q.delete();
         mcnt = 0;
      end else begin
         mrdy = !flush_i && (q.size() == 0 || (q.size() == 1 && out_ready_i));
         hs   = q.size() > 0 && !flush_i && out_ready_i;
         if (in_valid_i && !mrdy && mcnt < 65535) mcnt++;
         if (flush_i) begin
            q.delete();
         end else if (in_valid_i && mrdy) begin
            q.delete();
            for (int k = 0; k < NRET; k++) begin
               if (in_slot_valid_i[k]) begin
                  slot_t s;
                  s.d   = in_data_i[k*DW +: DW];
                  s.idx = k;
                  q.push_back(s);
               end
            end
         end else if (hs) begin
            void'(q.pop_front());
         end
      end
   end

   always @(negedge clk_i) begin
      bit e_vld;
      bit e_rdy;
      e_vld = q.size() > 0 && !flush_i;
      e_rdy = !flush_i && (q.size() == 0 || (q.size() == 1 && out_ready_i));
      check("m_valid", 64'(out_valid_o), 64'(e_vld));
      check("m_busy",  64'(busy_o), 64'(q.size() > 0));
      check("m_ready", 64'(in_ready_o), 64'(e_rdy));
      if (e_vld) begin
         check("m_data", 64'(out_data_o), 64'(q[0].d));
         check("m_idx",  64'(out_idx_o), 64'(q[0].idx));
         check("m_last", 64'(out_last_o), 64'(q.size() == 1));
      end else if (q.size() == 0) begin
         check("m_idle_data", 64'(out_data_o), 64'd0);
         check("m_idle_idx",  64'(out_idx_o), 64'd0);
         check("m_idle_last", 64'(out_last_o), 64'd0);
      end
`ifdef INGRESS_STALL_CNT_EN
      check("m_stall_cnt", 64'(stall_cnt_o), 64'(mcnt));
`endif
   end

   localparam logic [DW-1:0] A = 32'hAAAA_0001;
   localparam logic [DW-1:0] B = 32'hBBBB_0002;
   localparam logic [DW-1:0] C = 32'hCCCC_0003;
   localparam logic [DW-1:0] D = 32'hDDDD_0004;

   task automatic drive(input logic v, input logic [NRET-1:0] m, input logic [NRET*DW-1:0] d,
                        input logic ordy, input logic fl);
      in_valid_i      = v;
      in_slot_valid_i = m;
      in_data_i       = d;
      out_ready_i     = ordy;
      flush_i         = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic out_is(input string name, input logic v, input logic [DW-1:0] d,
                         input logic [IW-1:0] i, input logic l);
      check({name, "_valid"}, 64'(out_valid_o), 64'(v));
      check({name, "_data"},  64'(out_data_o), 64'(d));
      check({name, "_idx"},   64'(out_idx_o), 64'(i));
      check({name, "_last"},  64'(out_last_o), 64'(l));
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      tick();
      rst_ni = 1'b1;
      #1;
   endtask

   initial begin
      rst_ni = 1'b1;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      #2;
      do_reset();
      out_is("reset", 1'b0, '0, '0, 1'b0);
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_ready", 64'(in_ready_o), 64'd1);

      // Full bundle, downstream always ready.
      drive(1'b1, 2'b11, {B, A}, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      out_is("s1_a", 1'b1, A, 1'b0, 1'b0);
      tick();
      out_is("s1_b", 1'b1, B, 1'b1, 1'b1);
      tick();
      out_is("s1_idle", 1'b0, '0, '0, 1'b0);

      // Sparse bundle then all-empty bundle.
      drive(1'b1, 2'b10, {B, D}, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'b00, {C, D}, 1'b1, 1'b0);
      out_is("s2_b", 1'b1, B, 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      out_is("s2_empty", 1'b0, '0, '0, 1'b0);
      check("s2_busy", 64'(busy_o), 64'd0);
      drive(1'b1, 2'b00, {C, D}, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      check("s2_busy_after_empty", 64'(busy_o), 64'd0);
      tick();

      // Back-to-back bundles.
      drive(1'b1, 2'b11, {B, A}, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'b01, {D, C}, 1'b1, 1'b0);
      out_is("s3_a", 1'b1, A, 1'b0, 1'b0);
      check("s3_ready_a", 64'(in_ready_o), 64'd0);
      tick();
      out_is("s3_b", 1'b1, B, 1'b1, 1'b1);
      check("s3_ready_b", 64'(in_ready_o), 64'd1);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      out_is("s3_c", 1'b1, C, 1'b0, 1'b1);
      tick();
      out_is("s3_idle", 1'b0, '0, '0, 1'b0);

      // Downstream stall for five cycles on slot A.
      do_reset();
      drive(1'b1, 2'b11, {B, A}, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 2'b11, {D, C}, 1'b0, 1'b0);
         out_is("s4_hold", 1'b1, A, 1'b0, 1'b0);
         check("s4_ready", 64'(in_ready_o), 64'd0);
         tick();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
`ifdef INGRESS_STALL_CNT_EN
      check("s4_stall_cnt", 64'(stall_cnt_o), 64'd5);
`endif
      out_is("s4_a", 1'b1, A, 1'b0, 1'b0);
      tick();
      out_is("s4_b", 1'b1, B, 1'b1, 1'b1);
      tick();

      // Flush while slot A is presented.
      drive(1'b1, 2'b11, {B, A}, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'b11, {D, C}, 1'b1, 1'b1);
      check("s5_flush_valid", 64'(out_valid_o), 64'd0);
      check("s5_flush_ready", 64'(in_ready_o), 64'd0);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      out_is("s5_after", 1'b0, '0, '0, 1'b0);
      check("s5_busy", 64'(busy_o), 64'd0);
      tick();
      check("s5_no_b", 64'(out_valid_o), 64'd0);

      // Reset in the middle of a drain.
      drive(1'b1, 2'b11, {B, A}, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      out_is("s6_a", 1'b1, A, 1'b0, 1'b0);
      rst_ni = 1'b0;
      #1;
      out_is("s6_rst", 1'b0, '0, '0, 1'b0);
      check("s6_rst_busy", 64'(busy_o), 64'd0);
      tick();
      rst_ni = 1'b1;
      #1;
      check("s6_ready", 64'(in_ready_o), 64'd1);
      tick();
      out_is("s6_idle", 1'b0, '0, '0, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
